mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single-port main memory between the instruction-fetch requester and the load/store data requester. Each accepted request becomes a fixed-latency read or a single-cycle write, completed with a one-cycle done pulse. The block sits between the control unit's fetch/memory sequencing and the memory, and owns all of the memory's address, write-enable and write-data pins.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 3, memory read latency in cycles from address presented to data valid; must be ≥1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch read request, level
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted, one-cycle pulse
- if_done  out  1  fetch read data valid, one-cycle pulse
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request, level
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted, one-cycle pulse
- d_done  out  1  data transaction complete, one-cycle pulse; carries read data for reads
- d_rdata  out  DATA_W  data read data
- mem_addr  out  ADDR_W  memory address
- mem_wr  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight (state ≠ IDLE)

## Operation
- States: IDLE, READ, WRITE.
- IDLE with no request: stay in IDLE.
- IDLE with a request: arbitrate combinationally.
  - On the edge, latch owner, address and wdata.
  - Go to READ (fetch, or data with d_we=0) or WRITE (data with d_we=1).
  - Clear the latency counter.
- Fixed priority: data beats fetch when both are asserted.
- READ: drive mem_addr = latched address, mem_wr = 0. Stay MEM_LAT cycles.
  - On the edge ending the last cycle, capture mem_rdata into the owner's rdata register and return to IDLE.
- WRITE: one cycle with mem_wr = 1, mem_addr and mem_wdata from the latch. Then return to IDLE.
- Grant: the owner's gnt is high in the first READ/WRITE cycle only.
  - The requester drops req on seeing gnt, or a new transaction is accepted in the next IDLE cycle.
- Done: the owner's done is high for the single cycle after the transaction leaves READ/WRITE.
  - if_rdata/d_rdata hold their value until the next read by the same owner.
- req is ignored outside IDLE. A done cycle is an IDLE cycle and may accept a new request.
- mem_addr and mem_wdata hold their last value in IDLE. mem_wr is high only in WRITE.
- Counter width: $clog2(MEM_LAT+1). The counter is compared to MEM_LAT-1 and never wraps.

## Timing
- Reset values: all outputs 0, including mem_addr, mem_wdata and both rdata. State IDLE, counter 0, last_owner = FETCH.
- Read (req in cycle 0): gnt in cycle 1, mem_addr valid cycles 1..MEM_LAT, done + rdata in cycle MEM_LAT+1.
- Write (req in cycle 0): gnt and mem_wr in cycle 1, done in cycle 2.
- Back-to-back throughput: one read per MEM_LAT+1 cycles, one write per 2 cycles.
- Reset mid-transaction: return to IDLE on that edge.
  - No done pulse for the abandoned transaction.
  - mem_wr is low from the next cycle.
  - The rdata registers are cleared.
- Both requests in the same IDLE cycle: only one gnt. The loser stays pending and is served at its next IDLE evaluation.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - When both requests are asserted, grant the owner that is not last_owner.
  - last_owner updates on every accept.
  - After reset the first conflict goes to data.
- ARB_RR_EN undefined: fixed data-over-fetch priority. last_owner is not implemented.

## Structure
- Shared CPU package holds:
  - owner_t enum: OWN_FETCH, OWN_DATA
  - arb_state_t enum: IDLE, READ, WRITE
  - MEM_LAT default constant, also used by the control unit for fetch wait counts
- One sub-module: arb_pick.
  - Combinational two-way picker.
  - Inputs: if_req, d_req, last_owner.
  - Outputs: grant_valid, grant_owner.
  - Contains the ARB_RR_EN variants.

## Test plan
All scenarios use MEM_LAT=3.
- Lone fetch: if_req=1 cycle 0, if_addr=0x40, mem_rdata=0x20080005 during cycles 1-3 -> if_gnt cycle 1; mem_addr=0x40 cycles 1-3; if_done=1 and if_rdata=0x20080005 in cycle 4; busy high cycles 1-3.
- Data write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_wr=1 only in cycle 1 with those values; d_done cycle 2.
- Conflict, fixed priority: if_req and d_req (read, 0x200) both high cycle 0 -> d_gnt cycle 1; d_done cycle 4; if_gnt cycle 5.
- Conflict with ARB_RR_EN: three consecutive dual-request arbitrations -> grant order data, fetch, data.
- Reset during READ cycle 2 -> IDLE and busy=0 in cycle 3; no done pulse; rdata = 0; a fresh request is accepted normally afterward.
- Back-to-back: if_req held high through the done cycle -> second if_gnt one cycle after the first if_done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU definitions: requester ownership, arbiter states and default memory latency.
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_t;

  // Default main-memory read latency; the control unit sizes its fetch waits from this too.
  localparam int MEM_LAT_DEF = 3;

  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-way combinational requester picker: fixed data-over-fetch priority,
// or alternation on conflicts when ARB_RR_EN is defined.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_owner
);

  always_comb begin
    grant_valid = if_req | d_req;
    grant_owner = OWN_FETCH;
`ifdef ARB_RR_EN
    if (if_req && d_req) begin
      grant_owner = (last_owner == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (d_req) begin
      grant_owner = OWN_DATA;
    end
`else
    if (d_req) begin
      grant_owner = OWN_DATA;
    end
`endif
  end

`ifndef ARB_RR_EN
  // Fixed priority has no history; the input is kept only for a uniform port list.
  owner_t w_unused_last_owner;
  assign w_unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares single-port main memory between fetch and load/store requesters.
// Fixed-latency reads, single-cycle writes; ARB_RR_EN selects round-robin over data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int             CNT_W    = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_done;
  logic              r_d_done;
  owner_t            w_last_owner;
  logic              w_grant_valid;
  owner_t            w_grant_owner;
  logic              w_accept;
  logic              w_read_last;
  logic              w_leave;
  logic              w_first;

`ifdef ARB_RR_EN
  owner_t r_last_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_owner <= OWN_FETCH;
    end else if (w_accept) begin
      r_last_owner <= w_grant_owner;
    end
  end

  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = OWN_FETCH;
`endif

  arb_pick u_arb_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_owner  (w_last_owner),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_read_last = 1'b0;
    w_leave     = 1'b0;
    w_first     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_grant_owner == OWN_DATA && d_we) ? WRITE : READ;
        end
      end
      READ: begin
        w_first = (r_cnt == '0);
        if (r_cnt == CNT_LAST) begin
          w_read_last = 1'b1;
          w_leave     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WRITE: begin
        w_first     = 1'b1;
        w_leave     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_owner     <= OWN_FETCH;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
    end else begin
      r_if_done <= w_leave && (r_owner == OWN_FETCH);
      r_d_done  <= w_leave && (r_owner == OWN_DATA);
      if (w_accept) begin
        r_owner <= w_grant_owner;
        r_cnt   <= '0;
        if (w_grant_owner == OWN_DATA) begin
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
        end else begin
          r_mem_addr <= if_addr;
        end
      end else if (r_state == READ && !w_read_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_read_last) begin
        if (r_owner == OWN_DATA) begin
          r_d_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = w_first && (r_owner == OWN_FETCH);
  assign d_gnt     = w_first && (r_owner == OWN_DATA);
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wr    = (r_state == WRITE);
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=3; expected grant order follows ARB_RR_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_done;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_done;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_if_done;
    logic [31:0] e_if_rdata;
    logic        e_d_gnt;
    logic        e_d_done;
    logic [31:0] e_d_rdata;
    logic [31:0] e_mem_addr;
    logic        e_mem_wr;
    logic [31:0] e_mem_wdata;
    logic        e_busy;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  logic exp_d[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h20080005,
               1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0, 1'b1};
    tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h20080005,
               1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h20080005,
               1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0, 1'b1};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
               1'b0, 1'b1, 32'h20080005, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0, 1'b0};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0,
               1'b0, 1'b0, 32'h20080005, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0, 1'b0};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
               1'b0, 1'b0, 32'h20080005, 1'b1, 1'b0, 32'h0, 32'h100, 1'b1, 32'hDEADBEEF, 1'b1};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
               1'b0, 1'b0, 32'h20080005, 1'b0, 1'b1, 32'h0, 32'h100, 1'b0, 32'hDEADBEEF, 1'b0};

    do_reset();
    chk("rst.if_gnt", 32'(if_gnt), 0);
    chk("rst.d_gnt", 32'(d_gnt), 0);
    chk("rst.if_done", 32'(if_done), 0);
    chk("rst.d_done", 32'(d_done), 0);
    chk("rst.if_rdata", if_rdata, 0);
    chk("rst.d_rdata", d_rdata, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.mem_wr", 32'(mem_wr), 0);
    chk("rst.busy", 32'(busy), 0);

    // Lone fetch followed by a data write, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d.if_gnt", i), 32'(if_gnt), 32'(tbl[i].e_if_gnt));
      chk($sformatf("v%0d.if_done", i), 32'(if_done), 32'(tbl[i].e_if_done));
      chk($sformatf("v%0d.if_rdata", i), if_rdata, tbl[i].e_if_rdata);
      chk($sformatf("v%0d.d_gnt", i), 32'(d_gnt), 32'(tbl[i].e_d_gnt));
      chk($sformatf("v%0d.d_done", i), 32'(d_done), 32'(tbl[i].e_d_done));
      chk($sformatf("v%0d.d_rdata", i), d_rdata, tbl[i].e_d_rdata);
      chk($sformatf("v%0d.mem_addr", i), mem_addr, tbl[i].e_mem_addr);
      chk($sformatf("v%0d.mem_wr", i), 32'(mem_wr), 32'(tbl[i].e_mem_wr));
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata, tbl[i].e_mem_wdata);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
      if_req    = tbl[i].if_req;
      if_addr   = tbl[i].if_addr;
      d_req     = tbl[i].d_req;
      d_we      = tbl[i].d_we;
      d_addr    = tbl[i].d_addr;
      d_wdata   = tbl[i].d_wdata;
      mem_rdata = tbl[i].mem_rdata;
      step();
    end

    // Simultaneous requests from reset: data first, fetch waits and is served after d_done.
    do_reset();
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    step();
    chk("cf.c1.d_gnt", 32'(d_gnt), 1);
    chk("cf.c1.if_gnt", 32'(if_gnt), 0);
    chk("cf.c1.mem_addr", mem_addr, 32'h200);
    chk("cf.c1.mem_wr", 32'(mem_wr), 0);
    d_req = 1'b0; mem_rdata = 32'h11112222;
    step();
    step();
    step();
    chk("cf.c4.d_done", 32'(d_done), 1);
    chk("cf.c4.d_rdata", d_rdata, 32'h11112222);
    chk("cf.c4.if_gnt", 32'(if_gnt), 0);
    chk("cf.c4.if_done", 32'(if_done), 0);
    mem_rdata = 32'h0;
    step();
    chk("cf.c5.if_gnt", 32'(if_gnt), 1);
    chk("cf.c5.d_gnt", 32'(d_gnt), 0);
    chk("cf.c5.mem_addr", mem_addr, 32'h44);
    if_req = 1'b0;
    step();
    step();
    step();
    chk("cf.c8.if_done", 32'(if_done), 1);
    chk("cf.c8.d_done", 32'(d_done), 0);

    // Three back-to-back dual-request arbitrations.
`ifdef ARB_RR_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
`endif
    do_reset();
    if_req = 1'b1; if_addr = 32'h48;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("arb%0d.d_gnt", k), 32'(d_gnt), 32'(exp_d[k]));
      chk($sformatf("arb%0d.if_gnt", k), 32'(if_gnt), 32'(!exp_d[k]));
      step();
      step();
      step();
    end
    idle_inputs();

    // Reset in the second cycle of a read abandons it and clears read data.
    do_reset();
    if_req = 1'b1; if_addr = 32'h80;
    step();
    if_req = 1'b0; mem_rdata = 32'h5A5A0001;
    step();
    step();
    step();
    chk("rm.c4.if_rdata", if_rdata, 32'h5A5A0001);
    if_req = 1'b1; if_addr = 32'h84; mem_rdata = 32'hAAAA5555;
    step();
    chk("rm.c5.if_gnt", 32'(if_gnt), 1);
    if_req = 1'b0;
    step();
    chk("rm.c6.busy", 32'(busy), 1);
    reset = 1'b1;
    step();
    chk("rm.c7.busy", 32'(busy), 0);
    chk("rm.c7.mem_wr", 32'(mem_wr), 0);
    chk("rm.c7.if_rdata", if_rdata, 32'h0);
    chk("rm.c7.if_done", 32'(if_done), 0);
    reset = 1'b0; if_req = 1'b1; if_addr = 32'hC0; mem_rdata = 32'h0BADF00D;
    step();
    chk("rm.c8.if_done", 32'(if_done), 0);
    chk("rm.c8.if_gnt", 32'(if_gnt), 1);
    chk("rm.c8.mem_addr", mem_addr, 32'hC0);
    if_req = 1'b0;
    step();
    step();
    step();
    chk("rm.c11.if_done", 32'(if_done), 1);
    chk("rm.c11.if_rdata", if_rdata, 32'h0BADF00D);

    // Fetch request held through done: re-grant in the cycle after if_done.
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h12345678;
    step();
    chk("bb.c1.if_gnt", 32'(if_gnt), 1);
    step();
    step();
    step();
    chk("bb.c4.if_done", 32'(if_done), 1);
    chk("bb.c4.if_gnt", 32'(if_gnt), 0);
    chk("bb.c4.busy", 32'(busy), 0);
    step();
    chk("bb.c5.if_gnt", 32'(if_gnt), 1);
    chk("bb.c5.busy", 32'(busy), 1);
    if_req = 1'b0;
    step();
    step();
    step();

    // Held data write: one write every two cycles.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFEF00D;
    step();
    chk("bw.c1.d_gnt", 32'(d_gnt), 1);
    chk("bw.c1.mem_wr", 32'(mem_wr), 1);
    chk("bw.c1.mem_wdata", mem_wdata, 32'hCAFEF00D);
    d_addr = 32'h304; d_wdata = 32'h01234567;
    step();
    chk("bw.c2.d_done", 32'(d_done), 1);
    chk("bw.c2.mem_wr", 32'(mem_wr), 0);
    d_req = 1'b1;
    step();
    chk("bw.c3.d_gnt", 32'(d_gnt), 1);
    chk("bw.c3.mem_addr", mem_addr, 32'h304);
    chk("bw.c3.mem_wdata", mem_wdata, 32'h01234567);
    d_req = 1'b0;
    step();
    chk("bw.c4.d_done", 32'(d_done), 1);
    chk("bw.c4.mem_wdata", mem_wdata, 32'h01234567);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
